// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: front end for the radix-2 pipeline FFT.
// Pulls samples from a valid-qualified source and emits gap-free
// 2^N-sample frames on fft_en/fft_ad. Missing samples are zero-filled
// so a frame never tears. A post-reset holdoff keeps start blocked
// while the downstream FIFO leaves reset.
// Optional build macro SAMPLE_IDX_EN adds fft_idx/fft_sof outputs that
// carry the slot index alongside each emitted sample.
module fft_frame_sequencer #(
  parameter int WIDTH   = 16,
  parameter int N       = 9,
  parameter int HOLDOFF = 10,
  parameter int GAP     = 4,
  parameter int FCNT_W  = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              start,
  input  logic [FCNT_W-1:0] nframes,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  output logic              fft_en,
  output logic [WIDTH-1:0]  fft_ad,
  output logic              busy,
  output logic              done,
  output logic              underrun
`ifdef SAMPLE_IDX_EN
  ,
  output logic [N-1:0]      fft_idx,
  output logic              fft_sof
`endif
);

  // Counter widths stay at least one bit so HOLDOFF=0 / GAP<=1 still elaborate.
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF);
  localparam logic [GW-1:0] GAP_LAST  = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_HOLD,
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [HW-1:0]     hold_cnt_reg;
  logic [GW-1:0]     gap_cnt_reg;
  logic [N-1:0]      sample_cnt_reg;
  logic [FCNT_W-1:0] frame_cnt_reg;
  logic [FCNT_W-1:0] nframes_reg;
  logic [FCNT_W-1:0] frame_inc;

  // Frame count after the current frame completes; compared against the request.
  assign frame_inc = frame_cnt_reg + 1'b1;

  // The source may only hand over a sample while a frame slot is open.
  assign s_ready = (state_reg == S_RUN);

  // Sequencer FSM with all outputs registered; abort outranks every RUN/GAP transition.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_reg      <= S_HOLD;
      hold_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      sample_cnt_reg <= '0;
      frame_cnt_reg  <= '0;
      nframes_reg    <= '0;
      fft_en         <= 1'b0;
      fft_ad         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      underrun       <= 1'b0;
`ifdef SAMPLE_IDX_EN
      fft_idx        <= '0;
      fft_sof        <= 1'b0;
`endif
    end else begin
      // Outside an open slot the FFT input is quiet and done is a single pulse.
      fft_en <= 1'b0;
      fft_ad <= '0;
      done   <= 1'b0;
`ifdef SAMPLE_IDX_EN
      fft_idx <= '0;
      fft_sof <= 1'b0;
`endif
      case (state_reg)
        S_HOLD: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            state_reg <= S_IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end

        S_IDLE: begin
          if (start) begin
            nframes_reg    <= nframes;
            underrun       <= 1'b0;
            sample_cnt_reg <= '0;
            frame_cnt_reg  <= '0;
            gap_cnt_reg    <= '0;
            busy           <= 1'b1;
            state_reg      <= S_RUN;
          end
        end

        S_RUN: begin
          if (abort) begin
            sample_cnt_reg <= '0;
            frame_cnt_reg  <= '0;
            gap_cnt_reg    <= '0;
            busy           <= 1'b0;
            state_reg      <= S_IDLE;
          end else begin
            // Every slot is emitted; a missing sample becomes zero and is flagged.
            fft_en         <= 1'b1;
            fft_ad         <= s_valid ? s_data : '0;
            underrun       <= underrun | ~s_valid;
            sample_cnt_reg <= sample_cnt_reg + 1'b1;
`ifdef SAMPLE_IDX_EN
            fft_idx <= sample_cnt_reg;
            fft_sof <= (sample_cnt_reg == '0);
`endif
            if (sample_cnt_reg == '1) begin
              frame_cnt_reg <= frame_inc;
              if ((nframes_reg != '0) && (frame_inc == nframes_reg)) begin
                busy      <= 1'b0;
                state_reg <= S_DONE;
              end else if (GAP != 0) begin
                state_reg <= S_GAP;
              end
            end
          end
        end

        S_GAP: begin
          if (abort) begin
            sample_cnt_reg <= '0;
            frame_cnt_reg  <= '0;
            gap_cnt_reg    <= '0;
            busy           <= 1'b0;
            state_reg      <= S_IDLE;
          end else if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            state_reg   <= S_RUN;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        S_DONE: begin
          done      <= 1'b1;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: a time-based reference (runs described by
// their start edge, frame period and stop edge) is checked against the DUT
// every cycle, plus literal expectations for each directed scenario.
module tb_fft_frame_sequencer;

  localparam int WIDTH = 16;
  localparam int NB    = 9;
  localparam int H     = 10;
  localparam int G     = 4;
  localparam int FW    = 8;
  localparam int S     = 1 << NB;
  localparam int P     = S + G;
  localparam int NEVER = 32'h3fffffff;

  logic             clk = 1'b0;
  logic             areset;
  logic             start;
  logic [FW-1:0]    nframes;
  logic             abort;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             fft_en;
  logic [WIDTH-1:0] fft_ad;
  logic             busy;
  logic             done;
  logic             underrun;
`ifdef SAMPLE_IDX_EN
  logic [NB-1:0]    fft_idx;
  logic             fft_sof;
`endif

  fft_frame_sequencer #(
    .WIDTH(WIDTH), .N(NB), .HOLDOFF(H), .GAP(G), .FCNT_W(FW)
  ) dut (
    .clk(clk), .areset(areset), .start(start), .nframes(nframes),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fft_en(fft_en), .fft_ad(fft_ad), .busy(busy), .done(done),
    .underrun(underrun)
`ifdef SAMPLE_IDX_EN
    , .fft_idx(fft_idx), .fft_sof(fft_sof)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Scenario statistics gathered from the DUT outputs.
  int st_en_cnt, st_first_en, st_last_en, st_ramp_err;
  int st_first_busy, st_done_cnt, st_done_cyc;

  task automatic stats_clear();
    st_en_cnt = 0; st_first_en = -1; st_last_en = -1; st_ramp_err = 0;
    st_first_busy = -1; st_done_cnt = 0; st_done_cyc = -1;
  endtask

  // Reference: a run is fixed by its start edge t0 and frame count; slot
  // positions follow from (cycle - t0) modulo the frame period S+G.
  bit   m_inrst = 1'b1;
  bit   m_active = 1'b0;
  bit   m_aborted = 1'b0;
  bit   m_und = 1'b0;
  int   m_idle = NEVER;
  int   m_t0, m_nf, m_end, m_stop, m_last, m_idle_from;
  bit   p_start, p_abort, p_valid;
  logic [WIDTH-1:0] p_data;
  int   p_nf;

  // Per-cycle compare at the falling edge against the reference.
  always @(negedge clk) begin
    bit idle_prev, busy_prev;
    bit e_busy, e_en, e_done, e_rdy;
    int e_ad;
    if (!areset) begin
      chk("rst_fft_en", int'(fft_en), 0);
      chk("rst_fft_ad", int'(fft_ad), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_s_ready", int'(s_ready), 0);
      m_inrst = 1'b1; m_active = 1'b0; m_und = 1'b0; m_idle = NEVER;
    end else begin
      if (m_inrst) begin
        m_inrst = 1'b0;
        m_idle  = cyc + H + 1;
      end else begin
        idle_prev = (cyc - 1 >= m_idle) && (!m_active || cyc - 1 >= m_idle_from);
        busy_prev = m_active && (cyc - 1 >= m_t0) && (cyc - 1 < m_stop);
        if (idle_prev && p_start) begin
          m_active = 1'b1; m_aborted = 1'b0; m_t0 = cyc; m_nf = p_nf; m_und = 1'b0;
          if (m_nf != 0) begin
            m_end = m_t0 + (m_nf - 1) * P + S;
            m_stop = m_end; m_last = m_end; m_idle_from = m_end + 1;
          end else begin
            m_end = NEVER; m_stop = NEVER; m_last = NEVER; m_idle_from = NEVER;
          end
        end else if (busy_prev && p_abort) begin
          m_aborted = 1'b1; m_stop = cyc; m_last = cyc - 1; m_idle_from = cyc;
        end
      end
      e_busy = m_active && (cyc >= m_t0) && (cyc < m_stop);
      e_en   = m_active && (cyc > m_t0) && (cyc <= m_last) && (((cyc - m_t0 - 1) % P) < S);
      e_ad   = (e_en && p_valid) ? int'(p_data) : 0;
      if (e_en && !p_valid) m_und = 1'b1;
      e_done = m_active && !m_aborted && (m_nf != 0) && (cyc == m_end + 1);
      e_rdy  = e_busy && (((cyc - m_t0) % P) < S);
      chk("fft_en", int'(fft_en), int'(e_en));
      chk("fft_ad", int'(fft_ad), e_ad);
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("underrun", int'(underrun), int'(m_und));
      chk("s_ready", int'(s_ready), int'(e_rdy));
      if (fft_en) begin
        if (st_first_en < 0) st_first_en = cyc;
        st_last_en = cyc;
        if (int'(fft_ad) != (st_en_cnt % S)) st_ramp_err++;
        st_en_cnt++;
      end
      if (busy && st_first_busy < 0) st_first_busy = cyc;
      if (done) begin st_done_cnt++; st_done_cyc = cyc; end
    end
    p_start = start; p_abort = abort; p_valid = s_valid; p_data = s_data; p_nf = int'(nframes);
  end

  // Stimulus: slot counts samples the DUT has taken since the last start.
  int slot = 0;
  bit rdy_cur = 1'b0;
  bit drop = 1'b0;

  task automatic step();
    @(posedge clk);
    if (rdy_cur) slot++;
    #1;
    start = 1'b0;
    abort = 1'b0;
    s_data  = WIDTH'(slot % S);
    s_valid = !(drop && (slot % S) >= 100 && (slot % S) <= 102);
    rdy_cur = s_ready;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic issue_start(input int nf);
    start = 1'b1; nframes = FW'(nf); slot = 0; s_data = '0; s_valid = 1'b1;
  endtask

  task automatic start_run(input int nf);
    step();
    issue_start(nf);
    stats_clear();
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (st_done_cnt == 0 && n < limit) begin step(); n++; end
    chk("done_seen", int'(st_done_cnt > 0), 1);
    repeat (3) step();
  endtask

  task automatic wait_slot(input int target, input int limit);
    int n = 0;
    while (slot < target && n < limit) begin step(); n++; end
    chk("reach_slot", slot, target);
  endtask

  int r0, r2, abort_cyc;

  initial begin
    areset = 1'b0; start = 1'b0; abort = 1'b0; nframes = '0;
    s_valid = 1'b0; s_data = '0;
    stats_clear();
    repeat (3) step();
    areset = 1'b1; r0 = cyc;

    // Run 1: start during holdoff ignored, later start accepted, one ramp frame.
    wait_cyc(r0 + 5);  issue_start(1);
    wait_cyc(r0 + 12); issue_start(1);
    wait_done(700);
    chk("t1_first_busy", st_first_busy, r0 + 13);
    chk("t1_first_en", st_first_en, r0 + 14);
    chk("t1_en_cnt", st_en_cnt, 512);
    chk("t1_ramp_err", st_ramp_err, 0);
    chk("t1_done_cnt", st_done_cnt, 1);
    chk("t1_done_lag", st_done_cyc - st_last_en, 1);
    chk("t1_underrun", int'(underrun), 0);
    $display("run 1: nframes=1 en=%0d first_en=%0d done_cyc=%0d", st_en_cnt, st_first_en, st_done_cyc);

    // Run 2: three frames separated by GAP idle cycles.
    start_run(3);
    wait_done(2000);
    chk("t2_en_cnt", st_en_cnt, 1536);
    chk("t2_span", st_last_en - st_first_en + 1, 1544);
    chk("t2_done_cnt", st_done_cnt, 1);
    chk("t2_busy_after", int'(busy), 0);
    $display("run 2: nframes=3 en=%0d span=%0d", st_en_cnt, st_last_en - st_first_en + 1);

    // Run 3: source stalls for slots 100..102; zero-filled, frame length kept.
    drop = 1'b1;
    start_run(1);
    wait_done(700);
    drop = 1'b0;
    chk("t3_en_cnt", st_en_cnt, 512);
    chk("t3_zero_slots", st_ramp_err, 3);
    chk("t3_underrun", int'(underrun), 1);
    $display("run 3: nframes=1 en=%0d zero_filled=%0d", st_en_cnt, st_ramp_err);

    // Run 4: continuous mode, abort at slot 300 of frame 2.
    start_run(0);
    repeat (5) step();
    chk("t4_underrun_cleared", int'(underrun), 0);
    wait_slot(S + 300, 1200);
    abort = 1'b1; abort_cyc = cyc;
    repeat (6) step();
    chk("t4_en_cnt", st_en_cnt, S + 300);
    chk("t4_last_en", st_last_en, abort_cyc);
    chk("t4_done_cnt", st_done_cnt, 0);
    chk("t4_busy", int'(busy), 0);
    $display("run 4: nframes=0 aborted en=%0d", st_en_cnt);

    // Run 5: restart after abort begins at slot 0 of frame 1.
    start_run(1);
    wait_done(700);
    chk("t5_en_cnt", st_en_cnt, 512);
    chk("t5_ramp_err", st_ramp_err, 0);
    chk("t5_done_cnt", st_done_cnt, 1);
    $display("run 5: nframes=1 en=%0d", st_en_cnt);

    // Run 6: asynchronous reset at slot 200, then holdoff again.
    start_run(1);
    wait_slot(200, 400);
    #2 areset = 1'b0;
    #1;
    chk("t6_async_fft_en", int'(fft_en), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_s_ready", int'(s_ready), 0);
    repeat (3) step();
    areset = 1'b1; r2 = cyc;
    stats_clear();
    wait_cyc(r2 + 5);  issue_start(1);
    wait_cyc(r2 + 12); issue_start(1);
    wait_done(700);
    chk("t6_first_busy", st_first_busy, r2 + 13);
    chk("t6_first_en", st_first_en, r2 + 14);
    chk("t6_en_cnt", st_en_cnt, 512);
    $display("run 6: post-reset en=%0d first_busy=%0d", st_en_cnt, st_first_busy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
